// File: rtl/rs232_rx_stream.sv
// RS232 receiver: 2-flop synchroniser, mid-bit sampling FSM, single-word stb/ack holding register.
// Define RS232_RX_PARITY_EN for 8E1 frames with a parity_error pulse; the default build is 8N1.
module rs232_rx_stream #(
    parameter int CLOCK_FREQUENCY = 100000000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [31:0] output_rs232_rx,
    output logic        output_rs232_rx_stb,
    input  logic        output_rs232_rx_ack,
    output logic        framing_error,
    output logic        overrun_error
`ifdef RS232_RX_PARITY_EN
    ,
    output logic        parity_error
`endif
);

    localparam int CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF_BIT       = CLOCKS_PER_BIT / 2;
    localparam int CW             = $clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RS232_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t          state, state_next;
    logic            rx_meta, rxs;
    logic [CW-1:0]   baud_cnt, baud_next;
    logic [2:0]      bit_cnt, bit_next;
    logic [7:0]      shift_reg, shift_next;
    logic            char_valid;
    logic            frame_fail;
`ifdef RS232_RX_PARITY_EN
    logic            par_bad, par_bad_next;
    logic            par_fail;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        char_valid = 1'b0;
        frame_fail = 1'b0;
`ifdef RS232_RX_PARITY_EN
        par_bad_next = par_bad;
        par_fail     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_next = START;
                    baud_next  = '0;
                end
            end
            // Half a bit in: a line that has gone high again was only a glitch.
            START: begin
                if (baud_cnt == HALF_LAST) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = rxs ? IDLE : DATA;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_next  = '0;
                    shift_next = {rxs, shift_reg[7:1]};
                    bit_next   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef RS232_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
`ifdef RS232_RX_PARITY_EN
            PARITY: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_next    = '0;
                    par_bad_next = ^{shift_reg, rxs};
                    state_next   = STOP;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
`endif
            // A low stop bit wins over any parity verdict.
            STOP: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_next = '0;
                    if (rxs) begin
                        state_next = IDLE;
`ifdef RS232_RX_PARITY_EN
                        par_fail   = par_bad;
                        char_valid = !par_bad;
`else
                        char_valid = 1'b1;
`endif
                    end else begin
                        frame_fail = 1'b1;
                        state_next = BREAK;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            BREAK: begin
                if (rxs) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
`ifdef RS232_RX_PARITY_EN
            par_bad   <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_cnt   <= bit_next;
            shift_reg <= shift_next;
`ifdef RS232_RX_PARITY_EN
            par_bad   <= par_bad_next;
`endif
        end
    end

    // A completed byte may replace the held word only if that word leaves in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            output_rs232_rx     <= '0;
            output_rs232_rx_stb <= 1'b0;
            framing_error       <= 1'b0;
            overrun_error       <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            parity_error        <= 1'b0;
`endif
        end else begin
            framing_error <= frame_fail;
            overrun_error <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            parity_error  <= par_fail;
`endif
            if (char_valid) begin
                if (!output_rs232_rx_stb || output_rs232_rx_ack) begin
                    output_rs232_rx     <= {24'd0, shift_reg};
                    output_rs232_rx_stb <= 1'b1;
                end else begin
                    overrun_error <= 1'b1;
                end
            end else if (output_rs232_rx_ack) begin
                output_rs232_rx_stb <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rs232_rx_stream.sv
// Scoreboarded bench for rs232_rx_stream at 10 clocks per bit; frame rules modelled per character.
// Honours RS232_RX_PARITY_EN to exercise the 8E1 variant.
module tb_rs232_rx_stream;

    localparam int CPB = 10;
    localparam int HALF_PERIOD = 5;
`ifdef RS232_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int LATENCY = 2 + (FRAME_BITS - 1) * CPB + CPB / 2 + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx = 1'b1;
    logic        ack = 1'b0;
    logic [31:0] word;
    logic        stb;
    logic        framing;
    logic        overrun;
`ifdef RS232_RX_PARITY_EN
    logic        parity_err;
`endif

    rs232_rx_stream #(
        .CLOCK_FREQUENCY(1000000),
        .BAUD_RATE      (100000)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .rx                 (rx),
        .output_rs232_rx    (word),
        .output_rs232_rx_stb(stb),
        .output_rs232_rx_ack(ack),
        .framing_error      (framing),
        .overrun_error      (overrun)
`ifdef RS232_RX_PARITY_EN
        ,
        .parity_error       (parity_err)
`endif
    );

    always #HALF_PERIOD clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  exp_q[$];
    int          exp_framing = 0, got_framing = 0;
    int          exp_overrun = 0, got_overrun = 0;
    int          exp_parity = 0, got_parity = 0;
    logic        ack_level = 1'b1;
    logic        ack_rand = 1'b0;
    longint      start_time = 0;
    longint      rise_time = 0;
    logic        prev_stb = 1'b0;
    logic        prev_xfer = 1'b0;
    logic [31:0] prev_word = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Frame outcome from the line rules alone: bad stop, bad parity, full holding register, or a new word.
    task automatic modelFrame(input logic [7:0] data, input logic par, input logic stop);
        logic par_ok;
        par_ok = 1'b1;
`ifdef RS232_RX_PARITY_EN
        par_ok = ((^data) ^ par) == 1'b0;
`endif
        if (!stop)                                         exp_framing++;
        else if (!par_ok)                                  exp_parity++;
        else if (!ack_rand && !ack_level && exp_q.size() > 0) exp_overrun++;
        else                                               exp_q.push_back(data);
    endtask

    // Drives up to nbits of a frame, each bit CPB clocks wide; entry and exit at posedge+1.
    task automatic applyStimulus(input logic [7:0] data, input logic par, input logic stop, input int nbits);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
`ifdef RS232_RX_PARITY_EN
        bits.push_back(par);
`endif
        bits.push_back(stop);
        start_time = $time - 1;
        for (int i = 0; i < nbits && i < bits.size(); i++) begin
            if (i == bits.size() - 1) modelFrame(data, par, stop);
            rx = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic sendByte(input logic [7:0] data);
        applyStimulus(data, ^data, 1'b1, FRAME_BITS);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic holdLow(input int n);
        rx = 1'b0;
        idle(n);
        rx = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) idle(1);
        checkOutput(name, exp_q.size(), 0);
        idle(5);
    endtask

    task automatic checkFlags(input string name);
        checkOutput({name, "_framing"}, got_framing, exp_framing);
        checkOutput({name, "_overrun"}, got_overrun, exp_overrun);
        checkOutput({name, "_parity"},  got_parity,  exp_parity);
    endtask

    always @(posedge clk) begin
        #1;
        ack = ack_rand ? 1'($urandom_range(0, 1)) : ack_level;
    end

    // Monitor: pops the scoreboard on each transfer and checks hold/drop behaviour of the holding register.
    always @(negedge clk) begin
        if (!rst) begin
            prev_stb  = 1'b0;
            prev_xfer = 1'b0;
        end else begin
            if (framing) got_framing++;
            if (overrun) got_overrun++;
`ifdef RS232_RX_PARITY_EN
            if (parity_err) got_parity++;
`endif
            if (stb && !prev_stb) rise_time = $time - HALF_PERIOD;
            if (prev_xfer) checkOutput("stb_after_xfer", {31'd0, stb}, 32'd0);
            if (prev_stb && !prev_xfer && stb) checkOutput("word_hold", word, prev_word);
            if (stb && ack) begin
                if (exp_q.size() == 0) checkOutput("unexpected_word", word, 32'hxxxxxxxx);
                else checkOutput("word", word, {24'd0, exp_q.pop_front()});
            end
            prev_stb  = stb;
            prev_xfer = stb && ack;
            prev_word = word;
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] b;
        #1;
        checkOutput("reset_stb", {31'd0, stb}, 32'd0);
        checkOutput("reset_word", word, 32'd0);
        checkOutput("reset_flags", {30'd0, framing, overrun}, 32'd0);
        idle(3);
        rst = 1'b1;
        idle(5);

        $display("[TB] single byte 0xA5");
        sendByte(8'hA5);
        drain("a5_drain");
        checkOutput("stb_latency", 32'(rise_time - start_time), 32'(LATENCY * 10));

        $display("[TB] back-to-back 0x3C 0xFF 0x00");
        sendByte(8'h3C);
        sendByte(8'hFF);
        sendByte(8'h00);
        drain("b2b_drain");
        checkFlags("b2b");

        $display("[TB] overrun with ack held low");
        ack_level = 1'b0;
        idle(2);
        sendByte(8'h11);
        sendByte(8'h22);
        idle(3);
        checkOutput("held_stb", {31'd0, stb}, 32'd1);
        checkOutput("held_word", word, 32'h11);
        checkFlags("overrun");
        ack_level = 1'b1;
        drain("overrun_drain");

        $display("[TB] glitch, break, recovery");
        holdLow(5);
        idle(3 * CPB);
        checkFlags("glitch");
        holdLow(30 * CPB);
        exp_framing++;
        idle(2 * CPB);
        checkFlags("break");
        sendByte(8'h5A);
        drain("break_drain");

        $display("[TB] reset mid-character");
        applyStimulus(8'h81, ^8'h81, 1'b1, 4);
        rst = 1'b0;
        #1;
        checkOutput("rst_stb", {31'd0, stb}, 32'd0);
        checkOutput("rst_outputs", word | {30'd0, framing, overrun}, 32'd0);
        idle(3);
        rst = 1'b1;
        idle(2 * CPB);
        sendByte(8'h42);
        drain("rst_drain");

`ifdef RS232_RX_PARITY_EN
        $display("[TB] parity good and bad");
        applyStimulus(8'h07, 1'b1, 1'b1, FRAME_BITS);
        applyStimulus(8'h07, 1'b0, 1'b1, FRAME_BITS);
        drain("parity_drain");
        checkFlags("parity");
`endif

        $display("[TB] randomized characters with random ack");
        ack_rand = 1'b1;
        for (int i = 0; i < 25; i++) begin
            b = 8'($urandom_range(0, 255));
            idle($urandom_range(0, 2) * $urandom_range(0, 15));
            sendByte(b);
        end
        ack_rand = 1'b0;
        drain("random_drain");
        checkFlags("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
